// File: rtl/if_id_buffer_pkg.sv
// Shared fetch/decode pipeline definitions: the IF/ID beat type, the
// bubble constants and the state encoding of the IF/ID skid buffer.
package if_id_buffer_pkg;

  // One fetched beat as handed from fetch to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_flow_t;

  // addi x0,x0,0 : the canonical RISC-V NOP used as a bubble.
  localparam logic [31:0] IF_ID_NOP_INSTR = 32'h0000_0013;

  // pc shown alongside the bubble instruction.
  localparam logic [31:0] IF_ID_BUBBLE_PC = 32'h0000_0000;

  // Occupancy of the two-entry buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } if_id_buf_state_t;

  // Build the beat presented to decode when no real instruction is held.
  function automatic if_id_flow_t make_bubble(input logic [31:0] pc,
                                              input logic [31:0] instr);
    if_id_flow_t b;
    b.pc    = pc;
    b.instr = instr;
    return b;
  endfunction

endpackage

// File: rtl/if_id_buffer_skid.sv
// Skid entry of the IF/ID buffer: a plain load-enabled data register.
// Its validity is tracked by the owning buffer's state, so it carries no
// reset; its contents are only ever observed after a qualified load.
module if_id_buffer_skid #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_reg;

  // Capture the incoming beat only when the buffer parks it here.
  always_ff @(posedge clk) begin
    if (load) begin
      data_reg <= d;
    end
  end

  assign q = data_reg;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID two-entry skid buffer between fetch and decode.
// Beats enter under in_valid/in_ready and leave in order under
// out_valid/out_ready; a one-cycle decode stall is absorbed by the skid
// entry. in_ready is registered so out_ready never reaches it
// combinationally. flush empties the buffer synchronously. When empty the
// output shows a NOP bubble.
// Optional build macro: IF_ID_STALL_CNT_EN adds the stall_cycles counter.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = IF_ID_NOP_INSTR,
  parameter logic [31:0] BUBBLE_PC = IF_ID_BUBBLE_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  if_id_flow_t inflow,
  output logic        out_valid,
  input  logic        out_ready,
  output if_id_flow_t outflow
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  if_id_buf_state_t state_reg;
  if_id_buf_state_t state_next;
  logic             in_ready_reg;

  if_id_flow_t      main_reg;
  if_id_flow_t      main_next;
  logic             main_load;
  logic             skid_load;
  if_id_flow_t      skid_q;

  logic             push;
  logic             pop;

  assign push      = in_valid & in_ready_reg;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state_reg != EMPTY);
  assign in_ready  = in_ready_reg;

  // Next occupancy and which storage entry captures what this cycle.
  always_comb begin
    state_next = state_reg;
    main_load  = 1'b0;
    skid_load  = 1'b0;
    main_next  = inflow;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            state_next = ONE;
            main_load  = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            state_next = TWO;
            skid_load  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can move the state.
          if (pop) begin
            state_next = ONE;
            main_load  = 1'b1;
            main_next  = skid_q;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  // Occupancy and the registered ready; reset forces an idle, ready buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != TWO);
    end
  end

  // Head entry: loaded from fetch or promoted from the skid entry.
  always_ff @(posedge clk) begin
    if (main_load) begin
      main_reg <= main_next;
    end
  end

  if_id_buffer_skid #(
    .W($bits(if_id_flow_t))
  ) u_skid (
    .clk  (clk),
    .load (skid_load),
    .d    (inflow),
    .q    (skid_q)
  );

  // Present the head beat, or the bubble so stale storage never leaks out.
  always_comb begin
    if (out_valid) begin
      outflow = main_reg;
    end else begin
      outflow = make_bubble(BUBBLE_PC, NOP_INSTR);
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Count cycles where decode holds back a real instruction; wraps freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= 32'd0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: table of directed vectors,
// hand-written reset/stall sequences, and randomized traffic compared
// against a queue-based reference model.
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  if_id_flow_t inflow;
  logic        out_valid;
  logic        out_ready;
  if_id_flow_t outflow;
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  if_id_buffer dut (
    .clk       (clk),
    .reset     (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inflow    (inflow),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outflow   (outflow)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int passed = 0;
  int total  = 0;

  // Reference model: an ordered queue of at most two beats.
  if_id_flow_t model_q[$];
  logic        model_ready;
  logic [31:0] model_stall;

  localparam logic [63:0] BUBBLE = {IF_ID_BUBBLE_PC, IF_ID_NOP_INSTR};

  typedef struct {
    bit          f;
    bit          iv;
    logic [31:0] pc;
    bit          ordy;
    bit          e_valid;
    bit          e_ready;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {pc[15:0], 16'h0033} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    model_q.delete();
    model_ready = 1'b1;
    model_stall = 32'd0;
  endtask

  // Apply one clock edge to the model using the pre-edge inputs.
  task automatic model_edge(input bit f, input bit iv, input if_id_flow_t flow, input bit ordy);
    bit push;
    bit pop;
    push = iv && model_ready;
    pop  = (model_q.size() > 0) && ordy;
    if (model_q.size() > 0 && !ordy) model_stall = model_stall + 32'd1;
    if (f) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(flow);
    end
    model_ready = (model_q.size() < 2);
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic drive_step(input bit f, input bit iv, input logic [31:0] pc,
                            input logic [31:0] instr, input bit ordy);
    flush        = f;
    in_valid     = iv;
    inflow.pc    = pc;
    inflow.instr = instr;
    out_ready    = ordy;
    @(posedge clk);
    model_edge(f, iv, inflow, ordy);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [63:0] e;
    e = (model_q.size() > 0) ? 64'(model_q[0]) : BUBBLE;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(model_ready));
    chk({tag, ".outflow"}, 64'(outflow), e);
`ifdef IF_ID_STALL_CNT_EN
    chk({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(model_stall));
`endif
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inflow    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] e;
    bit f, iv, ordy;
    logic [31:0] pc;

    // f, iv, pc, out_ready | exp valid, exp ready, exp pc
    vecs[0]  = '{0, 1, 32'h00, 1, 1, 1, 32'h00};
    vecs[1]  = '{0, 1, 32'h04, 1, 1, 1, 32'h04};
    vecs[2]  = '{0, 1, 32'h08, 1, 1, 1, 32'h08};
    vecs[3]  = '{0, 0, 32'h00, 1, 0, 1, 32'h00};
    vecs[4]  = '{0, 1, 32'h10, 1, 1, 1, 32'h10};
    vecs[5]  = '{0, 1, 32'h14, 0, 1, 0, 32'h10};
    vecs[6]  = '{0, 0, 32'h00, 0, 1, 0, 32'h10};
    vecs[7]  = '{0, 0, 32'h00, 1, 1, 1, 32'h14};
    vecs[8]  = '{0, 0, 32'h00, 1, 0, 1, 32'h00};
    vecs[9]  = '{0, 1, 32'h20, 0, 1, 1, 32'h20};
    vecs[10] = '{0, 1, 32'h24, 0, 1, 0, 32'h20};
    vecs[11] = '{1, 1, 32'h18, 0, 0, 1, 32'h00};
    vecs[12] = '{0, 0, 32'h00, 1, 0, 1, 32'h00};
    vecs[13] = '{0, 1, 32'h30, 1, 1, 1, 32'h30};
    vecs[14] = '{1, 1, 32'h34, 1, 0, 1, 32'h00};
    vecs[15] = '{0, 0, 32'h00, 1, 0, 1, 32'h00};

    do_reset();
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.outflow", 64'(outflow), 64'h0000_0000_0000_0013);

    // Directed table: streaming, skid fill/drain, flush in TWO and ONE.
    for (int i = 0; i < 16; i++) begin
      drive_step(vecs[i].f, vecs[i].iv, vecs[i].pc, mk_instr(vecs[i].pc), vecs[i].ordy);
      e = vecs[i].e_valid ? {vecs[i].e_pc, mk_instr(vecs[i].e_pc)} : BUBBLE;
      $display("vec %0d: flush=%0d in_valid=%0d pc=%h out_ready=%0d -> out_valid=%0d in_ready=%0d out_pc=%h",
               i, vecs[i].f, vecs[i].iv, vecs[i].pc, vecs[i].ordy, out_valid, in_ready, outflow.pc);
      chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].e_ready));
      chk($sformatf("vec%0d.outflow", i), 64'(outflow), e);
    end

    // Asynchronous reset while full, then check no stale beat survives.
    drive_step(0, 1, 32'h38, mk_instr(32'h38), 0);
    drive_step(0, 1, 32'h3C, mk_instr(32'h3C), 0);
    check_model("pre_reset");
    #2;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    $display("async reset asserted mid-cycle: out_valid=%0d in_ready=%0d", out_valid, in_ready);
    chk("async_reset.out_valid", 64'(out_valid), 64'd0);
    chk("async_reset.in_ready", 64'(in_ready), 64'd1);
    chk("async_reset.outflow", 64'(outflow), BUBBLE);
`ifdef IF_ID_STALL_CNT_EN
    chk("async_reset.stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    #1;
    drive_step(0, 1, 32'h40, mk_instr(32'h40), 0);
    $display("post reset push pc=40 -> out_pc=%h", outflow.pc);
    chk("post_reset.outflow", 64'(outflow), {32'h40, mk_instr(32'h40)});
    drive_step(0, 0, 32'h0, 32'h0, 1);
    chk("post_reset_drain.out_valid", 64'(out_valid), 64'd0);
    check_model("post_reset_drain");

`ifdef IF_ID_STALL_CNT_EN
    // Stall counter: five stalled cycles, survives flush, wraps at all-ones.
    do_reset();
    drive_step(0, 1, 32'h50, mk_instr(32'h50), 0);
    for (int i = 0; i < 5; i++) drive_step(0, 0, 32'h0, 32'h0, 0);
    $display("stall run of 5 -> stall_cycles=%0d", stall_cycles);
    chk("stall.five", 64'(stall_cycles), 64'd5);
    drive_step(1, 0, 32'h0, 32'h0, 1);
    chk("stall.after_flush", 64'(stall_cycles), 64'd5);
    drive_step(0, 1, 32'h60, mk_instr(32'h60), 1);
    force dut.stall_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_reg;
    model_stall = 32'hFFFF_FFFF;
    drive_step(0, 0, 32'h0, 32'h0, 0);
    $display("stall from all-ones -> stall_cycles=%h", stall_cycles);
    chk("stall.wrap", 64'(stall_cycles), 64'd0);
`endif

    // Randomized traffic against the queue model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      f    = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      pc   = $urandom;
      $display("rand %0d: flush=%0d push=%0d pop=%0d pc=%h",
               c, f, iv && model_ready, ordy && (model_q.size() > 0), pc);
      drive_step(f, iv, pc, $urandom, ordy);
      check_model($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Two-entry skid buffer between the fetch stage and the decode stage.
- Accepts fetch beats (pc and instr, as one if_id_flow_t) under a valid/ready handshake and presents them to decode in order.
- Absorbs a one-cycle decode stall without dropping the beat that is in flight.
- Supports a synchronous flush on a taken branch or jump, and emits a NOP bubble whenever it holds no valid beat.

Parameters:
- NOP_INSTR, 32'h0000_0013, instruction word driven on outflow.instr when out_valid=0 (addi x0,x0,0).
- BUBBLE_PC, 32'h0000_0000, pc driven on outflow.pc when out_valid=0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  discard all buffered beats and the beat offered this cycle.
- in_valid  input  1  fetch offers inflow this cycle.
- in_ready  output  1  buffer can accept a beat; registered.
- inflow  input  if_id_flow_t  fetched pc and instr.
- out_valid  output  1  outflow holds a real instruction.
- out_ready  input  1  decode consumes outflow this cycle.
- outflow  output  if_id_flow_t  oldest buffered beat, or the bubble.
- stall_cycles  output  32  only present with IF_ID_STALL_CNT_EN.

Behaviour:
- Storage is a main register (head) and a skid register (second entry). Both are loaded on the rising clk edge.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- States:
  - EMPTY: 0 entries.
  - ONE: main entry valid.
  - TWO: main and skid entries valid.
- Transitions when flush=0:
  - EMPTY + push -> ONE, main<=inflow.
  - ONE + push + pop -> ONE, main<=inflow.
  - ONE + push, no pop -> TWO, skid<=inflow.
  - ONE + pop, no push -> EMPTY.
  - TWO + pop -> ONE, main<=skid.
  - TWO without pop -> hold.
  - A push cannot occur in TWO because in_ready=0.
- Output and ready signals:
  - out_valid = (state != EMPTY).
  - outflow = main when out_valid=1, otherwise {BUBBLE_PC, NOP_INSTR}. This is a combinational mux after the register.
  - in_ready is registered and equals 1 exactly when the next state is not TWO. This removes any combinational path from out_ready to in_ready.
- Latency: a beat pushed in cycle N appears on outflow in cycle N+1. There is zero-bubble throughput when out_ready=1 continuously.
- Flush:
  - Synchronous and highest priority.
  - Next state is EMPTY and in_ready becomes 1.
  - Any push or pop in the flush cycle has no effect on buffer contents.
  - A pop in the flush cycle still counts as consumed by decode; the flush only blocks later beats.
- Reset:
  - Asserting reset (low) at any time, including mid-transfer, immediately forces state EMPTY, out_valid=0, in_ready=1, outflow=bubble, and stall_cycles=0.
  - Contents of main and skid are don't-care and must never be observable.
- Data integrity:
  - main and skid are loaded only on the qualifying push/pop conditions above.
  - With out_valid=1 and out_ready=0, outflow is stable cycle to cycle.
  - Beats leave strictly in push order. None are duplicated or lost except through flush.
- X-safety: inflow is ignored whenever push=0.

Optional Feature:
- Macro: IF_ID_STALL_CNT_EN.
- With the macro defined:
  - Port stall_cycles (32-bit) exists.
  - It increments by 1 on every cycle where out_valid=1 and out_ready=0.
  - It wraps 32'hFFFF_FFFF -> 0.
  - It is cleared only by reset, not by flush.
- Without the macro: the port and the counter are absent, and all other behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - if_id_flow_t {pc[31:0], instr[31:0]}, already used by fetch.
  - The constant NOP_INSTR value.
  - The state enum if_id_buf_state_t {EMPTY, ONE, TWO}.
- No sub-module. Optionally, a generic skid_reg sub-module for the skid entry plus its valid bit; the counter stays inline.

Test Plan:
- Reset release, idle inputs -> out_valid=0, in_ready=1, outflow={32'h0, 32'h0000_0013}.
- Stream pc 0x00,0x04,0x08 with in_valid=1 and out_ready=1 -> outflow.pc 0x00,0x04,0x08 on consecutive cycles, each one cycle after its push, with in_ready held at 1.
- Push 0x10; hold out_ready=0 while pushing 0x14 -> state TWO, in_ready=0, outflow.pc stays 0x10. Then out_ready=1 -> 0x10 then 0x14 are delivered, and in_ready=1 one cycle after the first pop.
- In state TWO, assert flush with in_valid=1 and pc 0x18 -> next cycle out_valid=0, in_ready=1, and 0x18 never appears on outflow.
- Drop reset low mid-stream in state ONE -> out_valid=0 within the same cycle, without waiting for a clk edge. After release, the first new push 0x40 appears with no stale data.
- IF_ID_STALL_CNT_EN: hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cycles=5. A flush leaves it at 5. Preloading it to 32'hFFFF_FFFF and stalling one cycle -> 0.
